spi_cmd_wb_master: RTL and testbench

Command parser and Wishbone master that converts the byte stream from the SPI slave front-end into Wishbone single-word read/write cycles. It sits directly upstream of the RGB effects register block (wb_rgb_effects) and drives its 16-bit address / 32-bit data bus. Read data is returned as bytes to the SPI front-end for shift-out.

---
 rtl/spi_cmd_wb_master.sv | 177 +++++++++++++++++
 tb/tb_spi_cmd_wb_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_wb_master.sv
// SPI command-byte parser driving single-word Wishbone read/write cycles.
// Frame: CMD, ADDR_H, ADDR_L, then 4-byte write words (burst) or a 4-byte read response.
module spi_cmd_wb_master #(
  parameter int unsigned WB_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        frame_start,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] wb_addr,
  output logic [31:0] wb_wdata,
  input  logic [31:0] wb_rdata,
  output logic        wb_cyc,
  output logic        wb_we,
  input  logic        wb_ack,
  output logic        err_timeout,
  output logic        err_overrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_WDATA, S_WB_WR, S_WB_RD, S_TX, S_DROP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(WB_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        wr_op_q, wr_op_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        fs_pend_q, fs_pend_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_overrun_q, err_overrun_d;
  logic        wb_busy, cyc_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_op_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      fs_pend_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_op_q       <= wr_op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      fs_pend_q     <= fs_pend_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign wb_busy = (state_q == S_WB_WR) || (state_q == S_WB_RD);

  always_comb begin
    state_d       = state_q;
    wr_op_d       = wr_op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    fs_pend_d     = fs_pend_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q;
    cyc_done      = 1'b0;

    case (state_q)
      S_CMD: if (rx_valid) begin
        if (rx_data == 8'h01 || rx_data == 8'h02) begin
          wr_op_d = (rx_data == 8'h01);
          state_d = S_ADDR_H;
        end else begin
          state_d = S_DROP;
        end
      end
      S_ADDR_H: if (rx_valid) begin
        addr_d[15:8] = rx_data;
        state_d      = S_ADDR_L;
      end
      S_ADDR_L: if (rx_valid) begin
        addr_d[7:0] = rx_data;
        cnt_d       = '0;
        tmo_d       = '0;
        state_d     = wr_op_q ? S_WDATA : S_WB_RD;
      end
      S_WDATA: if (rx_valid) begin
        wdata_d = {wdata_q[23:0], rx_data};
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          tmo_d   = '0;
          state_d = S_WB_WR;
        end
      end
      S_WB_WR, S_WB_RD: begin
        if (frame_start) fs_pend_d = 1'b1;
        else if (rx_valid) err_overrun_d = 1'b1;
        // Ack on the expiry cycle still counts as a completed transfer.
        if (wb_ack) begin
          cyc_done = 1'b1;
          cnt_d    = '0;
          if (state_q == S_WB_WR) begin
            addr_d  = addr_q + 16'd1;
            state_d = S_WDATA;
          end else begin
            rdata_d = wb_rdata;
            state_d = S_TX;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_done      = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = S_DROP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
        if (cyc_done && (fs_pend_q || frame_start)) begin
          state_d       = S_CMD;
          fs_pend_d     = 1'b0;
          err_timeout_d = 1'b0;
          err_overrun_d = 1'b0;
        end
      end
      S_TX: begin
        if (rx_valid) err_overrun_d = 1'b1;
        if (tx_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_DROP;
        end
      end
      default: ;
    endcase

    // A new frame outside a bus cycle wins over any byte arriving with it.
    if (frame_start && !wb_busy) begin
      state_d       = S_CMD;
      wr_op_d       = wr_op_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      cnt_d         = '0;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;
    end
  end

  always_comb begin
    wb_cyc   = wb_busy;
    wb_we    = (state_q == S_WB_WR);
    tx_valid = (state_q == S_TX);
    case (cnt_q)
      2'd0:    tx_data = rdata_q[31:24];
      2'd1:    tx_data = rdata_q[23:16];
      2'd2:    tx_data = rdata_q[15:8];
      default: tx_data = rdata_q[7:0];
    endcase
  end

  assign wb_addr     = addr_q;
  assign wb_wdata    = wdata_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_spi_cmd_wb_master.sv
// Directed bench for spi_cmd_wb_master with a delayed-ack Wishbone slave model.
module tb_spi_cmd_wb_master;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_start;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic        wb_cyc;
  logic        wb_we;
  logic        wb_ack;
  logic        err_timeout;
  logic        err_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int ack_delay = 1;
  bit ack_en = 1'b1;
  int wait_cnt = 0;
  int cyc_cycles = 0;
  logic [48:0] log_q[$];

  spi_cmd_wb_master #(.WB_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_start(frame_start), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_rdata(wb_rdata), .wb_cyc(wb_cyc), .wb_we(wb_we), .wb_ack(wb_ack),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Bus monitor: counts cycles with cyc high and logs every acknowledged transfer.
  always @(posedge clk) begin
    if (wb_cyc) cyc_cycles <= cyc_cycles + 1;
    if (wb_cyc && wb_ack) log_q.push_back({wb_we, wb_addr, wb_wdata});
  end

  // Slave: ack after ack_delay+1 cycles of cyc, one-cycle pulse.
  initial begin
    wb_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_ack) begin
        wb_ack   = 1'b0;
        wait_cnt = 0;
      end else if (wb_cyc && ack_en) begin
        if (wait_cnt >= ack_delay) wb_ack = 1'b1;
        else wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [15:0] a, input logic [31:0] d);
    logic [48:0] e;
    if (idx < log_q.size()) begin
      e = log_q[idx];
      check({tag, "_we"}, 32'(e[48]), 32'd1);
      check({tag, "_addr"}, 32'(e[47:32]), 32'(a));
      check({tag, "_data"}, e[31:0], d);
    end else begin
      check({tag, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    idle(1);
    rx_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [15:0] a);
    send_byte(cmd);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  initial begin
    int base;
    int c0;
    logic [31:0] word;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; frame_start = 1'b0;
    tx_ready = 1'b0; wb_rdata = '0;
    idle(2);
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_addr", 32'(wb_addr), 32'd0);
    check("rst_wdata", wb_wdata, 32'd0);
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_txd", 32'(tx_data), 32'd0);
    check("rst_errs", 32'({err_timeout, err_overrun}), 32'd0);
    rst = 1'b0;
    idle(1);

    // Single write
    base = log_q.size();
    frame();
    hdr(8'h01, 16'h0001);
    send4(32'h000F0F0F);
    check("wr_cyc", 32'(wb_cyc), 32'd1);
    check("wr_we", 32'(wb_we), 32'd1);
    check("wr_addr", 32'(wb_addr), 32'h0001);
    check("wr_wdata", wb_wdata, 32'h000F0F0F);
    c0 = cyc_cycles;
    idle(3);
    check("wr_cyc_len", cyc_cycles - c0, 32'd2);
    check("wr_cyc_off", 32'(wb_cyc), 32'd0);
    check("wr_addr_inc", 32'(wb_addr), 32'h0002);
    check_wr("wr1", base, 16'h0001, 32'h000F0F0F);
    check("wr_count", log_q.size() - base, 32'd1);

    // Burst write and address wrap
    base = log_q.size();
    frame();
    hdr(8'h01, 16'h0000);
    send4(32'h00000003); idle(3);
    send4(32'h00040404); idle(3);
    check_wr("burst0", base, 16'h0000, 32'h00000003);
    check_wr("burst1", base + 1, 16'h0001, 32'h00040404);
    base = log_q.size();
    frame();
    hdr(8'h01, 16'hFFFF);
    send4(32'h11223344); idle(3);
    send4(32'h55667788); idle(3);
    check_wr("wrap0", base, 16'hFFFF, 32'h11223344);
    check_wr("wrap1", base + 1, 16'h0000, 32'h55667788);

    // Read with stalled tx_ready
    wb_rdata = 32'h00440000;
    frame();
    hdr(8'h02, 16'h0001);
    check("rd_cyc", 32'(wb_cyc), 32'd1);
    check("rd_we", 32'(wb_we), 32'd0);
    check("rd_addr", 32'(wb_addr), 32'h0001);
    idle(3);
    wb_rdata = 32'hDEADBEEF;
    word = 32'h00440000;
    for (int i = 0; i < 4; i++) begin
      check("tx_valid", 32'(tx_valid), 32'd1);
      check("tx_data", 32'(tx_data), 32'(word[31 - i*8 -: 8]));
      idle(3);
      check("tx_hold", 32'(tx_data), 32'(word[31 - i*8 -: 8]));
      tx_ready = 1'b1;
      idle(1);
      tx_ready = 1'b0;
    end
    check("tx_done", 32'(tx_valid), 32'd0);

    // Timeout, then ack exactly on the expiry cycle
    ack_en = 1'b0;
    frame();
    hdr(8'h01, 16'h0005);
    c0 = cyc_cycles;
    send4(32'hAABBCCDD);
    idle(20);
    check("tmo_len", cyc_cycles - c0, 32'd16);
    check("tmo_cyc", 32'(wb_cyc), 32'd0);
    check("tmo_err", 32'(err_timeout), 32'd1);
    ack_en = 1'b1;
    frame();
    check("tmo_clr", 32'(err_timeout), 32'd0);
    ack_delay = 15;
    base = log_q.size();
    hdr(8'h01, 16'h0006);
    send4(32'h01020304);
    idle(20);
    check_wr("tmo_edge", base, 16'h0006, 32'h01020304);
    check("tmo_edge_err", 32'(err_timeout), 32'd0);
    ack_delay = 1;

    // Aborted write and invalid command produce no bus activity
    c0 = cyc_cycles;
    frame();
    hdr(8'h01, 16'h0001);
    send_byte(8'h00);
    send_byte(8'h0F);
    frame();
    idle(5);
    frame();
    send_byte(8'h7F);
    hdr(8'h01, 16'h0000);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(5);
    check("abort_nocyc", cyc_cycles - c0, 32'd0);

    // Overrun during a slow write, then a deferred frame_start
    ack_delay = 3;
    base = log_q.size();
    frame();
    hdr(8'h01, 16'h0003);
    send4(32'hCAFEF00D);
    send_byte(8'h55);
    check("ovr_err", 32'(err_overrun), 32'd1);
    frame();
    check("pend_cyc", 32'(wb_cyc), 32'd1);
    idle(3);
    check("pend_done", 32'(wb_cyc), 32'd0);
    check("pend_clr", 32'(err_overrun), 32'd0);
    check_wr("ovr_wr", base, 16'h0003, 32'hCAFEF00D);
    hdr(8'h01, 16'h0007);
    send4(32'h12345678);
    idle(6);
    check_wr("pend_wr", base + 1, 16'h0007, 32'h12345678);
    ack_delay = 1;

    // Async reset during an open cycle
    ack_en = 1'b0;
    frame();
    hdr(8'h01, 16'h1234);
    send4(32'h0BADF00D);
    check("prerst_cyc", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_cyc", 32'(wb_cyc), 32'd0);
    check("arst_we", 32'(wb_we), 32'd0);
    check("arst_addr", 32'(wb_addr), 32'd0);
    check("arst_wdata", wb_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack_en = 1'b1;
    base = log_q.size();
    frame();
    hdr(8'h01, 16'h0009);
    send4(32'h00000009);
    idle(3);
    check_wr("post_rst", base, 16'h0009, 32'h00000009);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
